cif_dn_ack_arb: RTL and testbench

//  Shares the single DMA_RX/ENQDEQ mode2 ACK write port among CH_NUM CIF_DN per-channel ACK generators.

---
 rtl/cif_dn_ack_arb_pkg.sv | 12 +
 rtl/cif_rr_pick.sv | 33 +++
 rtl/cif_dn_ack_arb.sv | 128 ++++++++++++
 tb/tb_cif_dn_ack_arb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cif_dn_ack_arb_pkg.sv
// Shared types and constants for the CIF_DN mode2 ACK write-port arbiter.
package cif_dn_ack_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam int unsigned ACK_RP_W        = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 4096;

endpackage

// File: rtl/cif_rr_pick.sv
// Combinational round-robin pick: index of the first set request bit at or after ptr_i, cyclically.
module cif_rr_pick #(
  parameter int unsigned N = 32,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         any_req_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    logic        found;
    int unsigned c;
    logic [W-1:0] ci;
    found = 1'b0;
    idx_o = '0;
    c     = 0;
    ci    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c = 32'(ptr_i) + i;
      if (c >= N) c = c - N;
      ci = W'(c);
      if (!found && req_i[ci]) begin
        found = 1'b1;
        idx_o = ci;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/cif_dn_ack_arb.sv
// Round-robin arbiter sharing the ENQDEQ mode2 ACK write port among CH_NUM CIF_DN channels,
// with same-cycle ack return, ack-latency watchdog and sticky protocol error flags.
module cif_dn_ack_arb
  import cif_dn_ack_arb_pkg::*;
#(
  parameter int unsigned CH_NUM      = 32,
  parameter int unsigned CH_WIDTH    = $clog2(CH_NUM),
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                         user_clk,
  input  logic                         reset_n,
  input  logic [CH_NUM-1:0]            chx_que_wt_req,
  input  logic [CH_NUM*ACK_RP_W-1:0]   chx_que_wt_req_ack_rp,
  output logic [CH_NUM-1:0]            chx_que_wt_ack,
  output logic                         que_wt_req,
  output logic [CH_WIDTH-1:0]          que_wt_req_ch,
  output logic [ACK_RP_W-1:0]          que_wt_req_ack_rp,
  input  logic                         que_wt_ack,
  output logic                         arb_busy,
  output logic                         err_ack_timeout,
  output logic                         err_unexp_ack,
  input  logic                         err_clr
);

  localparam int unsigned        CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT_CYC);
  localparam logic [CH_WIDTH-1:0] CH_LAST = CH_WIDTH'(CH_NUM - 1);

  arb_state_e            state_q, state_d;
  logic [CH_WIDTH-1:0]   grant_ch_q, grant_ch_d;
  logic [CH_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  err_to_q, err_to_d;
  logic                  err_ux_q, err_ux_d;
  logic                  set_to, set_ux;
  logic                  pick_any;
  logic [CH_WIDTH-1:0]   pick_idx;
  logic [ACK_RP_W-1:0]   rp_arr [CH_NUM];

  for (genvar g = 0; g < CH_NUM; g++) begin : g_rp
    assign rp_arr[g] = chx_que_wt_req_ack_rp[g*ACK_RP_W +: ACK_RP_W];
  end

  cif_rr_pick #(
    .N (CH_NUM),
    .W (CH_WIDTH)
  ) u_pick (
    .req_i     (chx_que_wt_req),
    .ptr_i     (rr_ptr_q),
    .any_req_o (pick_any),
    .idx_o     (pick_idx)
  );

  always_ff @(posedge user_clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any)   state_d = WAIT;
      WAIT:    if (que_wt_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ack is returned in the same cycle so the channel drops its request before IDLE re-arbitrates.
  always_comb begin
    que_wt_req        = 1'b0;
    arb_busy          = 1'b0;
    que_wt_req_ack_rp = '0;
    chx_que_wt_ack    = '0;
    if (state_q == WAIT) begin
      que_wt_req        = 1'b1;
      arb_busy          = 1'b1;
      que_wt_req_ack_rp = rp_arr[grant_ch_q];
      if (que_wt_ack) chx_que_wt_ack[grant_ch_q] = 1'b1;
    end
  end

  assign que_wt_req_ch   = grant_ch_q;
  assign err_ack_timeout = err_to_q;
  assign err_unexp_ack   = err_ux_q;

  // While the watchdog stays saturated the set condition persists, so err_clr cannot clear it.
  always_comb begin
    grant_ch_d = grant_ch_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    set_to     = 1'b0;
    set_ux     = 1'b0;
    case (state_q)
      IDLE: begin
        set_ux = que_wt_ack;
        if (pick_any) begin
          grant_ch_d = pick_idx;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
        set_to = (TIMEOUT_CYC != 0) && (wait_cnt_d == CNT_MAX);
        if (que_wt_ack) rr_ptr_d = (grant_ch_q == CH_LAST) ? '0 : grant_ch_q + 1'b1;
      end
      default: ;
    endcase
    err_to_d = set_to | (err_to_q & ~err_clr);
    err_ux_d = set_ux | (err_ux_q & ~err_clr);
  end

  always_ff @(posedge user_clk) begin
    if (!reset_n) begin
      grant_ch_q <= '0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      err_to_q   <= 1'b0;
      err_ux_q   <= 1'b0;
    end else begin
      grant_ch_q <= grant_ch_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      err_to_q   <= err_to_d;
      err_ux_q   <= err_ux_d;
    end
  end

endmodule

// File: tb/tb_cif_dn_ack_arb.sv
// Self-checking bench for cif_dn_ack_arb: directed scenarios plus randomized traffic vs. a reference model.
module tb_cif_dn_ack_arb;

  localparam int unsigned N = 32;
  localparam int unsigned T = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*32-1:0] rp_flat;
  logic [N-1:0]    chx_ack;
  logic            q_req;
  logic [4:0]      q_ch;
  logic [31:0]     q_rp;
  logic            q_ack;
  logic            busy;
  logic            e_to;
  logic            e_ux;
  logic            clr;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  bit          m_busy;
  int unsigned m_grant, m_ptr, m_cnt;
  bit          m_eto, m_eux;

  always #5 clk = ~clk;

  cif_dn_ack_arb #(
    .CH_NUM      (N),
    .TIMEOUT_CYC (T)
  ) dut (
    .user_clk              (clk),
    .reset_n               (rst_n),
    .chx_que_wt_req        (req),
    .chx_que_wt_req_ack_rp (rp_flat),
    .chx_que_wt_ack        (chx_ack),
    .que_wt_req            (q_req),
    .que_wt_req_ch         (q_ch),
    .que_wt_req_ack_rp     (q_rp),
    .que_wt_ack            (q_ack),
    .arb_busy              (busy),
    .err_ack_timeout       (e_to),
    .err_unexp_ack         (e_ux),
    .err_clr               (clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned first_from(input logic [N-1:0] r, input int unsigned p);
    for (int unsigned k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // Called at a negedge with inputs already driven; checks outputs, advances one clock.
  task automatic step();
    logic [31:0] exp_ack, exp_rp;
    bit s_to, s_ux;
    #1;
    exp_ack = (m_busy && q_ack) ? (32'd1 << m_grant) : 32'd0;
    exp_rp  = m_busy ? rp_flat[32*m_grant +: 32] : 32'd0;
    chk("que_wt_req", q_req, m_busy);
    chk("arb_busy", busy, m_busy);
    chk("que_wt_req_ch", q_ch, m_grant);
    chk("que_wt_req_ack_rp", q_rp, exp_rp);
    chk("chx_que_wt_ack", chx_ack, exp_ack);
    chk("err_ack_timeout", e_to, m_eto);
    chk("err_unexp_ack", e_ux, m_eux);
    @(posedge clk);
    s_to = 1'b0;
    s_ux = 1'b0;
    if (!rst_n) begin
      m_busy = 0; m_grant = 0; m_ptr = 0; m_cnt = 0; m_eto = 0; m_eux = 0;
    end else begin
      if (!m_busy) begin
        s_ux = q_ack;
        if (req != '0) begin
          m_grant = first_from(req, m_ptr);
          m_busy  = 1;
          m_cnt   = 0;
        end
      end else begin
        if (m_cnt < T) m_cnt++;
        s_to = (m_cnt == T);
        if (q_ack) begin
          m_ptr  = (m_grant + 1) % N;
          m_busy = 0;
        end
      end
      m_eto = s_to | (m_eto & !clr);
      m_eux = s_ux | (m_eux & !clr);
    end
    @(negedge clk);
  endtask

  initial begin
    int unsigned exp_seq [5] = '{0, 1, 2, 3, 0};
    int acked;
    rst_n = 1'b0; req = '0; rp_flat = '0; q_ack = 1'b0; clr = 1'b0;
    m_busy = 0; m_grant = 0; m_ptr = 0; m_cnt = 0; m_eto = 0; m_eux = 0;
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;

    // Reset state and single-request latency
    chk("rst_req", q_req, 0);
    chk("rst_ch", q_ch, 0);
    chk("rst_ack", chx_ack, 0);
    chk("rst_errs", {e_to, e_ux, busy}, 0);
    req[5] = 1'b1;
    step();
    chk("lat_req", q_req, 1);
    chk("lat_ch", q_ch, 5);
    q_ack = 1'b1;
    #1 chk("lat_ack", chx_ack, 32'h20);
    step();
    q_ack = 1'b0; req[5] = 1'b0;

    // Round robin with held requests
    req = 32'h0000_000F;
    for (int g = 0; g < 5; g++) begin
      step();
      chk("rr_grant", q_ch, exp_seq[g]);
      q_ack = 1'b1;
      #1 chk("rr_onehot", chx_ack, 32'd1 << exp_seq[g]);
      step();
      q_ack = 1'b0;
    end
    req = '0;
    step();

    // Pointer update mid-WAIT
    rp_flat[3*32 +: 32] = 32'h40;
    req[3] = 1'b1;
    step(); step(); step();
    rp_flat[3*32 +: 32] = 32'h80;
    q_ack = 1'b1;
    #1 chk("rp_update", q_rp, 32'h80);
    step();
    q_ack = 1'b0; req[3] = 1'b0;
    step();

    // Channel clear while waiting
    req[7] = 1'b1;
    step();
    req[7] = 1'b0;
    repeat (10) step();
    q_ack = 1'b1;
    #1 chk("clr_ack", chx_ack, 32'h80);
    step();
    q_ack = 1'b0;
    chk("clr_idle", busy, 0);
    step();

    // Watchdog
    req[2] = 1'b1;
    step();
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) chk("to_before", e_to, 0);
      if (i == 16) chk("to_at16", e_to, 1);
    end
    chk("to_still_req", q_req, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("to_clr_blocked", e_to, 1);
    q_ack = 1'b1;
    step();
    q_ack = 1'b0; req[2] = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("to_cleared", e_to, 0);

    // Unexpected ack and mid-WAIT reset
    q_ack = 1'b1;
    #1 chk("ux_noack", chx_ack, 0);
    step();
    q_ack = 1'b0;
    chk("ux_set", e_ux, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ux_cleared", e_ux, 0);
    req[9] = 1'b1;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req[9] = 1'b0;
    chk("rst_midwait", q_req, 0);
    step();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!req[c] && ($urandom % 8 == 0)) begin
          req[c] = 1'b1;
          rp_flat[32*c +: 32] = $urandom;
        end
      end
      if ($urandom % 4 == 0) rp_flat[32*($urandom % N) +: 32] = $urandom;
      if ($urandom % 64 == 0) req[$urandom % N] = 1'b0;
      q_ack = m_busy ? ($urandom % 4 == 0) : ($urandom % 50 == 0);
      clr   = ($urandom % 30 == 0);
      rst_n = ($urandom % 500 != 0);
      acked = (m_busy && q_ack && rst_n) ? int'(m_grant) : -1;
      step();
      if (acked >= 0) req[acked] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
